memory_access_stage: RTL and testbench
======================================

Name: memory_access_stage

Overview:
- Pipeline stage that sits after the execution stage and consumes its registered outputs: ALU result/address, load/store codes, store data, write-back select, rd address and rd write enable.
- Drives a valid/ready request and response interface to the data cache.
- Formats load data (byte lane select, sign/zero extension) and store data (lane replication, byte strobes).
- Registers the result toward write-back, and stalls upstream while an access is in flight.

Parameters:
- HIGH, 1'b1, asserted logic level
- LOW, 1'b0, deasserted logic level

Ports:
- CLK  in  1  clock; all state updates on the rising edge
- RST  in  1  synchronous, active-high reset
- STALL_IN  in  1  downstream stall; holds this stage's output registers
- CLEAR_IN  in  1  flush; sampled only in IDLE, turns the current input into a bubble
- RD_ADDRESS_IN  in  5  destination register
- ALU_OUT_IN  in  32  effective address (memory op) or ALU result
- DATA_CACHE_LOAD_IN  in  3  000 none, 001 LB, 010 LH, 011 LW, 100 LBU, 101 LHU; 110/111 treated as none
- DATA_CACHE_STORE_IN  in  2  00 none, 01 SB, 10 SH, 11 SW
- DATA_CACHE_STORE_DATA_IN  in  32  unaligned store source (rs2)
- WRITE_BACK_MUX_SELECT_IN  in  1  1 = load data, 0 = ALU_OUT_IN
- RD_WRITE_ENABLE_IN  in  1  register write enable
- DCACHE_REQ_VALID  out  1  request valid
- DCACHE_REQ_READY  in  1  cache accepts the request when VALID && READY
- DCACHE_REQ_WRITE  out  1  1 = store
- DCACHE_ADDR  out  32  {ALU_OUT_IN[31:2], 2'b00}
- DCACHE_WSTRB  out  4  byte enables (stores only; 0000 for loads)
- DCACHE_WDATA  out  32  lane-replicated store data
- DCACHE_RESP_VALID  in  1  one-cycle completion pulse for loads and stores
- DCACHE_RDATA  in  32  read word; valid with RESP_VALID
- STALL_OUT  out  1  hold upstream stages
- MISALIGNED_EXCEPTION  out  1  registered one-cycle pulse
- RD_ADDRESS_OUT  out  5  registered
- WB_DATA_OUT  out  32  registered
- RD_WRITE_ENABLE_OUT  out  1  registered

Behaviour:
- Reset:
  - state = IDLE.
  - All registered outputs 0.
  - DCACHE_REQ_VALID = 0.
  - Any outstanding cache transaction is abandoned; the cache shares RST.
- Memop definition: memop = (load code is 001..101) or (store code != 00).
- Misaligned conditions:
  - LH, LHU or SH with addr[0] = 1.
  - LW or SW with addr[1:0] != 00.
- Upstream contract: upstream holds all inputs stable while STALL_OUT = 1.
- IDLE:
  - Non-memop, or CLEAR_IN = 1, while STALL_IN = 0: output regs load in 1 cycle (bubble if CLEAR_IN). No request issued.
  - Misaligned memop while STALL_IN = 0: no request; MISALIGNED_EXCEPTION = 1 for one cycle; bubble (RD_WRITE_ENABLE_OUT = 0, WB_DATA_OUT = 0).
  - Aligned memop while STALL_IN = 0: DCACHE_REQ_VALID = 1 combinationally this cycle. If READY, go to WAIT_RESP; else go to REQ.
- REQ: VALID held high with ADDR/WRITE/WSTRB/WDATA stable until READY, then go to WAIT_RESP.
- WAIT_RESP, on RESP_VALID:
  - STALL_IN = 0: output regs load the result, go to IDLE.
  - STALL_IN = 1: result is captured in an internal hold register, go to DONE.
- DONE: when STALL_IN = 0, output regs load from the hold register, go to IDLE.
- STALL_OUT = STALL_IN | (IDLE & aligned memop & !CLEAR_IN) | REQ | (WAIT_RESP & !(RESP_VALID & !STALL_IN)) | (DONE & STALL_IN).
- Bubbles: while a memop is in flight and STALL_IN = 0, output regs load a bubble each cycle. This means RD_WRITE_ENABLE_OUT = 0 and RD_ADDRESS_OUT = 0.
- STALL_IN = 1: output regs hold their values. CLEAR_IN is ignored outside IDLE.
- Load formatting, with off = addr[1:0] latched at request:
  - Byte lane = RDATA[8*off+7 : 8*off].
  - Halfword lane = RDATA[16*off[1]+15 : 16*off[1]].
  - LB/LH: sign-extend. LBU/LHU: zero-extend. LW: the full word.
- Store formatting:
  - SB: WDATA = {4{d[7:0]}}, WSTRB = 0001 << off.
  - SH: WDATA = {2{d[15:0]}}, WSTRB = 0011 << off.
  - SW: WDATA = d, WSTRB = 1111.
- Write-back data:
  - Stores: result written with the input RD_WRITE_ENABLE_IN (normally 0).
  - WB_DATA_OUT = WRITE_BACK_MUX_SELECT_IN ? formatted load : ALU_OUT_IN.
- Minimum memop latency: 2 cycles (request cycle plus response cycle).
- Simultaneous READY and RESP_VALID in IDLE: RESP_VALID is ignored; a response is only accepted in WAIT_RESP.

Test Plan:
- Reset mid-access: load issued, RESP pending, RST = 1 -> next cycle state IDLE, REQ_VALID = 0, all outputs 0.
- LB at addr 0x1003, RDATA 0x80FF_FF7F, READY = 1, RESP 3 cycles later:
  - DCACHE_ADDR = 0x1000.
  - STALL_OUT high until the response cycle.
  - WB_DATA_OUT = 0xFFFF_FF80, RD_WRITE_ENABLE_OUT = 1.
  - LBU on the same data -> 0x0000_0080.
- SH at 0x2002, data 0x1234_ABCD, READY delayed 2 cycles:
  - VALID held 3 cycles with stable ADDR 0x2000, WSTRB 1100, WDATA 0xABCD_ABCD.
  - RD_WRITE_ENABLE_OUT = 0.
- LW at 0x3001 -> no request, MISALIGNED_EXCEPTION pulse of 1 cycle, bubble output, STALL_OUT = 0.
- RESP_VALID while STALL_IN = 1 -> state DONE, output regs unchanged; STALL_IN drops -> LHU data 0x0000_BEEF from RDATA 0xBEEF_0000 at off = 2 appears one cycle later.
- Non-memop ADD result 0x55 with CLEAR_IN = 1 -> bubble (RD_WRITE_ENABLE_OUT = 0); with CLEAR_IN = 0 -> WB_DATA_OUT = 0x55 after 1 cycle, no cache request.

Source files
------------

// File: rtl/memory_access_stage_if.sv
// Data-cache request/response bundle shared by the memory access stage and the cache.
interface memory_access_stage_if;
    logic        DCACHE_REQ_VALID;
    logic        DCACHE_REQ_READY;
    logic        DCACHE_REQ_WRITE;
    logic [31:0] DCACHE_ADDR;
    logic [3:0]  DCACHE_WSTRB;
    logic [31:0] DCACHE_WDATA;
    logic        DCACHE_RESP_VALID;
    logic [31:0] DCACHE_RDATA;

    modport master (
        output DCACHE_REQ_VALID, DCACHE_REQ_WRITE, DCACHE_ADDR, DCACHE_WSTRB, DCACHE_WDATA,
        input  DCACHE_REQ_READY, DCACHE_RESP_VALID, DCACHE_RDATA
    );

    modport slave (
        input  DCACHE_REQ_VALID, DCACHE_REQ_WRITE, DCACHE_ADDR, DCACHE_WSTRB, DCACHE_WDATA,
        output DCACHE_REQ_READY, DCACHE_RESP_VALID, DCACHE_RDATA
    );
endinterface

// File: rtl/memory_access_stage.sv
// Memory access stage: issues data-cache requests, formats load/store lanes and registers
// the write-back result, stalling upstream while an access is outstanding.
//
// state     | meaning
// IDLE      | accepting a new instruction; memops present their request combinationally
// REQ       | request presented, waiting for the cache to accept it
// WAIT_RESP | request accepted, waiting for the completion pulse
// DONE      | response captured in the hold register while downstream is stalled
module memory_access_stage #(
    parameter logic HIGH = 1'b1,
    parameter logic LOW  = 1'b0
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic                         STALL_IN,
    input  logic                         CLEAR_IN,
    input  logic [4:0]                   RD_ADDRESS_IN,
    input  logic [31:0]                  ALU_OUT_IN,
    input  logic [2:0]                   DATA_CACHE_LOAD_IN,
    input  logic [1:0]                   DATA_CACHE_STORE_IN,
    input  logic [31:0]                  DATA_CACHE_STORE_DATA_IN,
    input  logic                         WRITE_BACK_MUX_SELECT_IN,
    input  logic                         RD_WRITE_ENABLE_IN,
    memory_access_stage_if.master        dcache,
    output logic                         STALL_OUT,
    output logic                         MISALIGNED_EXCEPTION,
    output logic [4:0]                   RD_ADDRESS_OUT,
    output logic [31:0]                  WB_DATA_OUT,
    output logic                         RD_WRITE_ENABLE_OUT
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT_RESP, DONE} state_t;

    localparam logic [2:0] LD_LB  = 3'b001;
    localparam logic [2:0] LD_LH  = 3'b010;
    localparam logic [2:0] LD_LW  = 3'b011;
    localparam logic [2:0] LD_LBU = 3'b100;
    localparam logic [2:0] LD_LHU = 3'b101;
    localparam logic [1:0] ST_SB  = 2'b01;
    localparam logic [1:0] ST_SH  = 2'b10;
    localparam logic [1:0] ST_SW  = 2'b11;

    state_t state, state_nxt;

    logic        is_load, is_store, is_memop, is_half, is_word, misaligned, issue;
    logic [31:0] st_wdata;
    logic [3:0]  st_wstrb;

    // Request context, captured every IDLE cycle so it is frozen once the access leaves IDLE.
    logic [4:0]  ctx_rd;
    logic [31:0] ctx_alu;
    logic [2:0]  ctx_load;
    logic        ctx_wb_sel, ctx_we, ctx_write;
    logic [3:0]  ctx_wstrb;
    logic [31:0] ctx_wdata;

    logic [4:0]  hold_rd;
    logic [31:0] hold_data;
    logic        hold_we;

    logic [7:0]  lane_b;
    logic [15:0] lane_h;
    logic [31:0] load_data, wb_result;

    always_comb begin
        is_load    = (DATA_CACHE_LOAD_IN >= LD_LB) && (DATA_CACHE_LOAD_IN <= LD_LHU);
        is_store   = (DATA_CACHE_STORE_IN != 2'b00);
        is_memop   = is_load | is_store;
        is_half    = (DATA_CACHE_LOAD_IN == LD_LH) | (DATA_CACHE_LOAD_IN == LD_LHU) |
                     (DATA_CACHE_STORE_IN == ST_SH);
        is_word    = (DATA_CACHE_LOAD_IN == LD_LW) | (DATA_CACHE_STORE_IN == ST_SW);
        misaligned = (is_half & ALU_OUT_IN[0]) | (is_word & (ALU_OUT_IN[1:0] != 2'b00));
        issue      = !STALL_IN & !CLEAR_IN & is_memop & !misaligned;
    end

    always_comb begin
        st_wdata = '0;
        st_wstrb = '0;
        case (DATA_CACHE_STORE_IN)
            ST_SB: begin
                st_wdata = {4{DATA_CACHE_STORE_DATA_IN[7:0]}};
                st_wstrb = 4'b0001 << ALU_OUT_IN[1:0];
            end
            ST_SH: begin
                st_wdata = {2{DATA_CACHE_STORE_DATA_IN[15:0]}};
                st_wstrb = 4'b0011 << ALU_OUT_IN[1:0];
            end
            ST_SW: begin
                st_wdata = DATA_CACHE_STORE_DATA_IN;
                st_wstrb = 4'b1111;
            end
            default: ;
        endcase
    end

    always_comb begin
        if (state == IDLE) begin
            dcache.DCACHE_REQ_VALID = issue;
            dcache.DCACHE_REQ_WRITE = is_store;
            dcache.DCACHE_ADDR      = {ALU_OUT_IN[31:2], 2'b00};
            dcache.DCACHE_WSTRB     = st_wstrb;
            dcache.DCACHE_WDATA     = st_wdata;
        end else begin
            dcache.DCACHE_REQ_VALID = (state == REQ);
            dcache.DCACHE_REQ_WRITE = ctx_write;
            dcache.DCACHE_ADDR      = {ctx_alu[31:2], 2'b00};
            dcache.DCACHE_WSTRB     = ctx_wstrb;
            dcache.DCACHE_WDATA     = ctx_wdata;
        end
    end

    always_comb begin
        lane_b    = dcache.DCACHE_RDATA[{ctx_alu[1:0], 3'b000} +: 8];
        lane_h    = ctx_alu[1] ? dcache.DCACHE_RDATA[31:16] : dcache.DCACHE_RDATA[15:0];
        load_data = '0;
        case (ctx_load)
            LD_LB:   load_data = {{24{lane_b[7]}}, lane_b};
            LD_LH:   load_data = {{16{lane_h[15]}}, lane_h};
            LD_LW:   load_data = dcache.DCACHE_RDATA;
            LD_LBU:  load_data = {24'd0, lane_b};
            LD_LHU:  load_data = {16'd0, lane_h};
            default: ;
        endcase
        wb_result = ctx_wb_sel ? load_data : ctx_alu;
    end

    always_comb begin
        state_nxt = state;
        STALL_OUT = STALL_IN;
        case (state)
            IDLE: begin
                STALL_OUT = STALL_IN | (is_memop & !misaligned & !CLEAR_IN);
                if (issue) state_nxt = dcache.DCACHE_REQ_READY ? WAIT_RESP : REQ;
            end
            REQ: begin
                STALL_OUT = HIGH;
                if (dcache.DCACHE_REQ_READY) state_nxt = WAIT_RESP;
            end
            WAIT_RESP: begin
                STALL_OUT = STALL_IN | !dcache.DCACHE_RESP_VALID;
                if (dcache.DCACHE_RESP_VALID) state_nxt = STALL_IN ? DONE : IDLE;
            end
            DONE: begin
                if (!STALL_IN) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state                <= IDLE;
            ctx_rd               <= '0;
            ctx_alu              <= '0;
            ctx_load             <= '0;
            ctx_wb_sel           <= LOW;
            ctx_we               <= LOW;
            ctx_write            <= LOW;
            ctx_wstrb            <= '0;
            ctx_wdata            <= '0;
            hold_rd              <= '0;
            hold_data            <= '0;
            hold_we              <= LOW;
            RD_ADDRESS_OUT       <= '0;
            WB_DATA_OUT          <= '0;
            RD_WRITE_ENABLE_OUT  <= LOW;
            MISALIGNED_EXCEPTION <= LOW;
        end else begin
            state                <= state_nxt;
            MISALIGNED_EXCEPTION <= LOW;
            if (state == IDLE) begin
                ctx_rd     <= RD_ADDRESS_IN;
                ctx_alu    <= ALU_OUT_IN;
                ctx_load   <= DATA_CACHE_LOAD_IN;
                ctx_wb_sel <= WRITE_BACK_MUX_SELECT_IN;
                ctx_we     <= RD_WRITE_ENABLE_IN;
                ctx_write  <= is_store;
                ctx_wstrb  <= st_wstrb;
                ctx_wdata  <= st_wdata;
            end
            if ((state == WAIT_RESP) && dcache.DCACHE_RESP_VALID && STALL_IN) begin
                hold_rd   <= ctx_rd;
                hold_data <= wb_result;
                hold_we   <= ctx_we;
            end
            // Unless something below overrides it, every unstalled cycle emits a bubble.
            if (!STALL_IN) begin
                RD_ADDRESS_OUT      <= '0;
                WB_DATA_OUT         <= '0;
                RD_WRITE_ENABLE_OUT <= LOW;
                case (state)
                    IDLE: begin
                        if (!CLEAR_IN && !is_memop) begin
                            RD_ADDRESS_OUT      <= RD_ADDRESS_IN;
                            WB_DATA_OUT         <= ALU_OUT_IN;
                            RD_WRITE_ENABLE_OUT <= RD_WRITE_ENABLE_IN;
                        end else if (!CLEAR_IN && misaligned) begin
                            MISALIGNED_EXCEPTION <= HIGH;
                        end
                    end
                    WAIT_RESP: begin
                        if (dcache.DCACHE_RESP_VALID) begin
                            RD_ADDRESS_OUT      <= ctx_rd;
                            WB_DATA_OUT         <= wb_result;
                            RD_WRITE_ENABLE_OUT <= ctx_we;
                        end
                    end
                    DONE: begin
                        RD_ADDRESS_OUT      <= hold_rd;
                        WB_DATA_OUT         <= hold_data;
                        RD_WRITE_ENABLE_OUT <= hold_we;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_memory_access_stage.sv
// Bench for memory_access_stage: directed scenarios, then randomized traffic checked by a
// byte-level memory model and scoreboard queues drained by an independent monitor.
module tb_memory_access_stage;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        STALL_IN = 1'b0;
    logic        CLEAR_IN = 1'b0;
    logic [4:0]  RD_ADDRESS_IN = '0;
    logic [31:0] ALU_OUT_IN = '0;
    logic [2:0]  DATA_CACHE_LOAD_IN = '0;
    logic [1:0]  DATA_CACHE_STORE_IN = '0;
    logic [31:0] DATA_CACHE_STORE_DATA_IN = '0;
    logic        WRITE_BACK_MUX_SELECT_IN = 1'b0;
    logic        RD_WRITE_ENABLE_IN = 1'b0;
    logic        STALL_OUT, MISALIGNED_EXCEPTION, RD_WRITE_ENABLE_OUT;
    logic [4:0]  RD_ADDRESS_OUT;
    logic [31:0] WB_DATA_OUT;

    memory_access_stage_if dc();

    memory_access_stage dut (
        .CLK(CLK), .RST(RST), .STALL_IN(STALL_IN), .CLEAR_IN(CLEAR_IN),
        .RD_ADDRESS_IN(RD_ADDRESS_IN), .ALU_OUT_IN(ALU_OUT_IN),
        .DATA_CACHE_LOAD_IN(DATA_CACHE_LOAD_IN), .DATA_CACHE_STORE_IN(DATA_CACHE_STORE_IN),
        .DATA_CACHE_STORE_DATA_IN(DATA_CACHE_STORE_DATA_IN),
        .WRITE_BACK_MUX_SELECT_IN(WRITE_BACK_MUX_SELECT_IN),
        .RD_WRITE_ENABLE_IN(RD_WRITE_ENABLE_IN), .dcache(dc.master),
        .STALL_OUT(STALL_OUT), .MISALIGNED_EXCEPTION(MISALIGNED_EXCEPTION),
        .RD_ADDRESS_OUT(RD_ADDRESS_OUT), .WB_DATA_OUT(WB_DATA_OUT),
        .RD_WRITE_ENABLE_OUT(RD_WRITE_ENABLE_OUT)
    );

    always #5 CLK = ~CLK;

    typedef struct { logic [31:0] addr; logic wr; logic [3:0] wstrb; logic [31:0] wdata; } req_t;
    typedef struct { logic exc; logic [4:0] rd; logic [31:0] data; } ev_t;

    req_t        req_q[$];
    ev_t         ev_q[$];
    logic [7:0]  ref_bytes[64];
    logic [31:0] cache_mem[16];
    int          total = 0;
    int          bad = 0;
    bit          running = 1'b0;
    localparam int N_OPS = 400;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge CLK);
    endtask

    task automatic set_op(input logic [2:0] ld, input logic [1:0] st, input logic [31:0] addr,
                          input logic [31:0] sd, input logic [4:0] rd, input logic sel,
                          input logic we, input logic clr);
        DATA_CACHE_LOAD_IN       = ld;
        DATA_CACHE_STORE_IN      = st;
        ALU_OUT_IN               = addr;
        DATA_CACHE_STORE_DATA_IN = sd;
        RD_ADDRESS_IN            = rd;
        WRITE_BACK_MUX_SELECT_IN = sel;
        RD_WRITE_ENABLE_IN       = we;
        CLEAR_IN                 = clr;
    endtask

    task automatic nop();
        set_op(3'd0, 2'd0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    endtask

    // Load with immediate acceptance and a response three cycles after the request cycle.
    task automatic do_load(input string name, input logic [2:0] code, input logic [31:0] addr,
                           input logic [31:0] rdata, input logic [4:0] rd,
                           input logic [31:0] exp_addr, input logic [31:0] exp_wb);
        set_op(code, 2'd0, addr, 32'd0, rd, 1'b1, 1'b1, 1'b0);
        dc.DCACHE_REQ_READY = 1'b1;
        #1;
        chk({name, "_addr"}, dc.DCACHE_ADDR, exp_addr);
        chk({name, "_valid"}, 32'(dc.DCACHE_REQ_VALID), 32'd1);
        chk({name, "_stall0"}, 32'(STALL_OUT), 32'd1);
        step();
        dc.DCACHE_REQ_READY = 1'b0;
        for (int i = 1; i < 3; i++) begin
            #1 chk({name, "_stall_wait"}, 32'(STALL_OUT), 32'd1);
            step();
        end
        dc.DCACHE_RESP_VALID = 1'b1;
        dc.DCACHE_RDATA      = rdata;
        #1 chk({name, "_stall_resp"}, 32'(STALL_OUT), 32'd0);
        step();
        dc.DCACHE_RESP_VALID = 1'b0;
        nop();
        #1;
        chk({name, "_wb"}, WB_DATA_OUT, exp_wb);
        chk({name, "_we"}, 32'(RD_WRITE_ENABLE_OUT), 32'd1);
        chk({name, "_rd"}, 32'(RD_ADDRESS_OUT), 32'(rd));
    endtask

    task automatic gen_and_apply();
        int          kind, size, a;
        logic [2:0]  ld;
        logic [1:0]  st;
        logic [31:0] addr, sd, val;
        logic [4:0]  rd;
        logic        sel, we, clr, sgn;
        longint      v;
        req_t        r;
        kind = $urandom_range(0, 9);
        ld = 3'd0; st = 2'd0; sel = 1'b0; we = 1'b0; size = 0; a = 0;
        rd   = 5'($urandom_range(0, 31));
        sd   = $urandom();
        addr = $urandom();
        clr  = ($urandom_range(0, 7) == 0);
        if (kind < 3) begin
            we = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 4) == 0) ld = 3'($urandom_range(6, 7));
        end else if (kind < 7) begin
            ld = 3'($urandom_range(1, 5)); sel = 1'b1; we = 1'b1;
        end else begin
            st = 2'($urandom_range(1, 3)); we = ($urandom_range(0, 3) == 0);
        end
        if (ld == 3'd1 || ld == 3'd4 || st == 2'd1) size = 1;
        else if (ld == 3'd2 || ld == 3'd5 || st == 2'd2) size = 2;
        else if (ld == 3'd3 || st == 2'd3) size = 4;
        sgn = (ld == 3'd1 || ld == 3'd2);
        if (size != 0) begin
            a = $urandom_range(0, 63);
            if ($urandom_range(0, 3) != 0) a = a - (a % size);
            addr = ($urandom() & 32'hFFFF_FFC0) | 32'(a);
        end
        set_op(ld, st, addr, sd, rd, sel, we, clr);
        if (clr) return;
        if (size == 0) begin
            if (we) ev_q.push_back('{exc: 1'b0, rd: rd, data: addr});
            return;
        end
        if ((a % size) != 0) begin
            ev_q.push_back('{exc: 1'b1, rd: 5'd0, data: 32'd0});
            return;
        end
        r.addr  = addr & ~32'h3;
        r.wr    = (st != 2'd0);
        r.wstrb = r.wr ? 4'(((1 << size) - 1) << (a % 4)) : 4'h0;
        r.wdata = (size == 1) ? (sd & 32'hFF) * 32'h0101_0101 :
                  (size == 2) ? (sd & 32'hFFFF) * 32'h0001_0001 : sd;
        req_q.push_back(r);
        if (r.wr) begin
            for (int i = 0; i < size; i++) ref_bytes[a + i] = 8'(sd >> (8 * i));
            val = addr;
        end else begin
            v = 0;
            for (int i = 0; i < size; i++) v += longint'(ref_bytes[a + i]) << (8 * i);
            if (sgn && v >= (longint'(1) << (8 * size - 1))) v -= longint'(1) << (8 * size);
            val = 32'(v);
        end
        if (we) ev_q.push_back('{exc: 1'b0, rd: rd, data: val});
    endtask

    task automatic drive_random();
        int  cyc;
        bit  accepted, timed_out;
        timed_out = 1'b0;
        @(negedge CLK);
        for (int n = 0; n < N_OPS && !timed_out; n++) begin
            gen_and_apply();
            accepted = 1'b0;
            cyc = 0;
            while (!accepted) begin
                STALL_IN = ($urandom_range(0, 3) == 0);
                #4 accepted = !STALL_OUT;
                @(negedge CLK);
                cyc++;
                if (!accepted && cyc > 100) begin
                    total++; bad++;
                    $display("FAIL accept_timeout: op %0d still stalled after %0d cycles", n, cyc);
                    timed_out = 1'b1;
                    break;
                end
            end
        end
        nop();
        STALL_IN = 1'b0;
        repeat (6) @(negedge CLK);
        chk("events_left", 32'(ev_q.size()), 32'd0);
        chk("requests_left", 32'(req_q.size()), 32'd0);
        running = 1'b0;
    endtask

    task automatic cache_model();
        bit        pend;
        int        dly;
        logic [3:0] idx;
        req_t      e;
        pend = 1'b0; dly = 0; idx = '0;
        while (running) begin
            @(negedge CLK);
            dc.DCACHE_RESP_VALID = 1'b0;
            dc.DCACHE_RDATA      = $urandom();
            if (pend) begin
                if (dly == 0) begin
                    dc.DCACHE_RESP_VALID = 1'b1;
                    dc.DCACHE_RDATA      = cache_mem[idx];
                    pend = 1'b0;
                end else dly--;
            end
            dc.DCACHE_REQ_READY = 1'($urandom_range(0, 1));
            #4;
            if (dc.DCACHE_REQ_VALID && dc.DCACHE_REQ_READY) begin
                if (req_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL req_unexpected: got addr %h with nothing expected", dc.DCACHE_ADDR);
                end else begin
                    e = req_q.pop_front();
                    chk("req_addr", dc.DCACHE_ADDR, e.addr);
                    chk("req_write", 32'(dc.DCACHE_REQ_WRITE), 32'(e.wr));
                    chk("req_wstrb", 32'(dc.DCACHE_WSTRB), 32'(e.wstrb));
                    if (e.wr) chk("req_wdata", dc.DCACHE_WDATA, e.wdata);
                end
                idx = dc.DCACHE_ADDR[5:2];
                for (int b = 0; b < 4; b++)
                    if (dc.DCACHE_REQ_WRITE && dc.DCACHE_WSTRB[b])
                        cache_mem[idx][8*b +: 8] = dc.DCACHE_WDATA[8*b +: 8];
                pend = 1'b1;
                dly  = $urandom_range(0, 3);
            end
        end
        dc.DCACHE_REQ_READY  = 1'b0;
        dc.DCACHE_RESP_VALID = 1'b0;
    endtask

    task automatic monitor();
        bit  upd;
        ev_t e;
        upd = 1'b0;
        while (running) begin
            @(negedge CLK);
            #2;
            if (upd && (RD_WRITE_ENABLE_OUT || MISALIGNED_EXCEPTION)) begin
                if (ev_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL wb_unexpected: rd %0d data %h exc %0d", RD_ADDRESS_OUT,
                             WB_DATA_OUT, MISALIGNED_EXCEPTION);
                end else begin
                    e = ev_q.pop_front();
                    chk("ev_exc", 32'(MISALIGNED_EXCEPTION), 32'(e.exc));
                    chk("ev_rd", 32'(RD_ADDRESS_OUT), 32'(e.rd));
                    chk("ev_data", WB_DATA_OUT, e.data);
                    chk("ev_we", 32'(RD_WRITE_ENABLE_OUT), 32'(!e.exc));
                end
            end
            upd = !STALL_IN;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        dc.DCACHE_REQ_READY  = 1'b0;
        dc.DCACHE_RESP_VALID = 1'b0;
        dc.DCACHE_RDATA      = '0;
        nop();
        step(); step();
        #1;
        chk("rst_wb", WB_DATA_OUT, 32'd0);
        chk("rst_we", 32'(RD_WRITE_ENABLE_OUT), 32'd0);
        chk("rst_valid", 32'(dc.DCACHE_REQ_VALID), 32'd0);
        RST = 1'b0;
        step();

        // Reset while a load response is pending.
        set_op(3'd3, 2'd0, 32'h100, 32'd0, 5'd9, 1'b1, 1'b1, 1'b0);
        dc.DCACHE_REQ_READY = 1'b1;
        #1 chk("mid_valid", 32'(dc.DCACHE_REQ_VALID), 32'd1);
        step();
        dc.DCACHE_REQ_READY = 1'b0;
        nop();
        #1 chk("mid_wait_stall", 32'(STALL_OUT), 32'd1);
        RST = 1'b1;
        step();
        RST = 1'b0;
        #1;
        chk("mid_rst_stall", 32'(STALL_OUT), 32'd0);
        chk("mid_rst_valid", 32'(dc.DCACHE_REQ_VALID), 32'd0);
        chk("mid_rst_wb", WB_DATA_OUT, 32'd0);
        chk("mid_rst_rd", 32'(RD_ADDRESS_OUT), 32'd0);
        step();

        do_load("lb", 3'b001, 32'h1003, 32'h80FF_FF7F, 5'd5, 32'h1000, 32'hFFFF_FF80);
        step();
        do_load("lbu", 3'b100, 32'h1003, 32'h80FF_FF7F, 5'd6, 32'h1000, 32'h0000_0080);
        step();

        // SH with READY held off for two cycles.
        set_op(3'd0, 2'b10, 32'h2002, 32'h1234_ABCD, 5'd4, 1'b0, 1'b0, 1'b0);
        dc.DCACHE_REQ_READY = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (i == 2) dc.DCACHE_REQ_READY = 1'b1;
            #1;
            chk("sh_valid", 32'(dc.DCACHE_REQ_VALID), 32'd1);
            chk("sh_addr", dc.DCACHE_ADDR, 32'h2000);
            chk("sh_wstrb", 32'(dc.DCACHE_WSTRB), 32'hC);
            chk("sh_wdata", dc.DCACHE_WDATA, 32'hABCD_ABCD);
            chk("sh_write", 32'(dc.DCACHE_REQ_WRITE), 32'd1);
            step();
        end
        dc.DCACHE_REQ_READY  = 1'b0;
        dc.DCACHE_RESP_VALID = 1'b1;
        #1 chk("sh_resp_stall", 32'(STALL_OUT), 32'd0);
        step();
        dc.DCACHE_RESP_VALID = 1'b0;
        nop();
        #1;
        chk("sh_we", 32'(RD_WRITE_ENABLE_OUT), 32'd0);
        chk("sh_wb", WB_DATA_OUT, 32'h2002);

        // Misaligned LW.
        step();
        set_op(3'b011, 2'd0, 32'h3001, 32'd0, 5'd6, 1'b1, 1'b1, 1'b0);
        #1;
        chk("mis_valid", 32'(dc.DCACHE_REQ_VALID), 32'd0);
        chk("mis_stall", 32'(STALL_OUT), 32'd0);
        step();
        nop();
        #1;
        chk("mis_exc", 32'(MISALIGNED_EXCEPTION), 32'd1);
        chk("mis_we", 32'(RD_WRITE_ENABLE_OUT), 32'd0);
        chk("mis_wb", WB_DATA_OUT, 32'd0);
        step();
        #1 chk("mis_exc_pulse", 32'(MISALIGNED_EXCEPTION), 32'd0);

        // LHU whose response arrives under downstream stall.
        set_op(3'b101, 2'd0, 32'h4002, 32'd0, 5'd7, 1'b1, 1'b1, 1'b0);
        dc.DCACHE_REQ_READY = 1'b1;
        step();
        dc.DCACHE_REQ_READY  = 1'b0;
        STALL_IN             = 1'b1;
        dc.DCACHE_RESP_VALID = 1'b1;
        dc.DCACHE_RDATA      = 32'hBEEF_0000;
        #1 chk("done_resp_stall", 32'(STALL_OUT), 32'd1);
        step();
        dc.DCACHE_RESP_VALID = 1'b0;
        dc.DCACHE_RDATA      = 32'h0;
        #1;
        chk("done_hold_wb", WB_DATA_OUT, 32'd0);
        chk("done_hold_we", 32'(RD_WRITE_ENABLE_OUT), 32'd0);
        chk("done_stall", 32'(STALL_OUT), 32'd1);
        step();
        STALL_IN = 1'b0;
        #1 chk("done_release", 32'(STALL_OUT), 32'd0);
        step();
        nop();
        #1;
        chk("done_wb", WB_DATA_OUT, 32'h0000_BEEF);
        chk("done_we", 32'(RD_WRITE_ENABLE_OUT), 32'd1);
        chk("done_rd", 32'(RD_ADDRESS_OUT), 32'd7);

        // Non-memop with and without flush.
        set_op(3'd0, 2'd0, 32'h55, 32'd0, 5'd3, 1'b0, 1'b1, 1'b1);
        step();
        #1;
        chk("clr_we", 32'(RD_WRITE_ENABLE_OUT), 32'd0);
        chk("clr_wb", WB_DATA_OUT, 32'd0);
        CLEAR_IN = 1'b0;
        #1 chk("add_valid", 32'(dc.DCACHE_REQ_VALID), 32'd0);
        step();
        nop();
        #1;
        chk("add_wb", WB_DATA_OUT, 32'h55);
        chk("add_we", 32'(RD_WRITE_ENABLE_OUT), 32'd1);
        chk("add_rd", 32'(RD_ADDRESS_OUT), 32'd3);

        // A response pulse coinciding with the IDLE handshake must be ignored.
        set_op(3'b011, 2'd0, 32'h40, 32'd0, 5'd8, 1'b1, 1'b1, 1'b0);
        dc.DCACHE_REQ_READY  = 1'b1;
        dc.DCACHE_RESP_VALID = 1'b1;
        dc.DCACHE_RDATA      = 32'hDEAD_DEAD;
        step();
        dc.DCACHE_REQ_READY  = 1'b0;
        dc.DCACHE_RESP_VALID = 1'b0;
        #1 chk("idle_resp_ignored", 32'(STALL_OUT), 32'd1);
        dc.DCACHE_RESP_VALID = 1'b1;
        dc.DCACHE_RDATA      = 32'h1234_5678;
        step();
        dc.DCACHE_RESP_VALID = 1'b0;
        nop();
        #1 chk("idle_resp_wb", WB_DATA_OUT, 32'h1234_5678);

        // Randomized traffic against the byte-level memory model.
        RST = 1'b1;
        step(); step();
        RST = 1'b0;
        for (int w = 0; w < 16; w++) begin
            cache_mem[w] = $urandom();
            for (int b = 0; b < 4; b++) ref_bytes[4 * w + b] = cache_mem[w][8*b +: 8];
        end
        running = 1'b1;
        fork
            drive_random();
            cache_model();
            monitor();
        join

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
